// File: rtl/uart_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_deserializer
// Purpose  : Oversampling UART receiver with run-time frame format and a
//            ready/valid output carrying parity/framing/break/overrun status.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_deserializer #(
    parameter int DATA_WIDTH   = 8,
    parameter int OVERSAMPLING = 16,
    parameter int BAUD_DIV     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    input  logic [3:0]            cfgDataWidth,
    input  logic                  cfgParityEnable,
    input  logic                  cfgParityType,
    input  logic [1:0]            cfgStopBits,
    output logic [DATA_WIDTH-1:0] rxData,
    output logic                  rxValid,
    input  logic                  rxReady,
    output logic                  parityError,
    output logic                  framingError,
    output logic                  breakError,
    output logic                  overrunError
);

    localparam int c_DIV_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int c_OVS_W = $clog2(OVERSAMPLING);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(BAUD_DIV - 1);
    localparam logic [c_OVS_W-1:0] c_HALF_LAST = c_OVS_W'(OVERSAMPLING / 2 - 1);
    localparam logic [c_OVS_W-1:0] c_FULL_LAST = c_OVS_W'(OVERSAMPLING - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        STARTBIT  = 3'd1,
        DATABITS  = 3'd2,
        PARITYBIT = 3'd3,
        STOPBIT   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic                  r_rxSync1;
    logic                  r_rxSync2;
    logic [1:0]            r_syncPrimed;
    logic                  r_armed;
    logic [c_DIV_W-1:0]    r_divCnt;
    logic [c_OVS_W-1:0]    r_ovsCnt;
    logic [3:0]            r_bitCnt;
    logic [3:0]            r_cfgWidth;
    logic                  r_cfgParityEn;
    logic                  r_cfgOdd;
    logic                  r_cfgTwoStop;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_parAcc;
    logic                  r_allZero;
    logic                  r_parErr;
    logic                  r_frmErr;
    logic                  r_brkErr;
    logic                  r_frameDone;

    logic                  w_tick;
    logic                  w_midStart;
    logic                  w_bitSample;
    logic                  w_lastData;
    logic                  w_lastStop;
    logic                  w_startDet;
    logic [3:0]            w_widthClamped;
    logic [DATA_WIDTH-1:0] w_bitSel;

    assign w_tick         = (r_divCnt == c_DIV_LAST);
    assign w_midStart     = w_tick && (r_ovsCnt == c_HALF_LAST);
    assign w_bitSample    = w_tick && (r_ovsCnt == c_FULL_LAST);
    assign w_lastData     = (r_bitCnt == (r_cfgWidth - 4'd1));
    assign w_lastStop     = (r_bitCnt == 4'd1) || !r_cfgTwoStop;
    assign w_widthClamped = (cfgDataWidth >= 4'd5 && cfgDataWidth <= 4'd8) ? cfgDataWidth : 4'd8;
    assign w_bitSel       = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << r_bitCnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_startDet  = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_armed && !r_rxSync2) begin
                    w_startDet  = 1'b1;
                    w_nextState = STARTBIT;
                end
            end
            STARTBIT: begin
                if (w_midStart) begin
                    w_nextState = r_rxSync2 ? IDLE : DATABITS;
                end
            end
            DATABITS: begin
                if (w_bitSample && w_lastData) begin
                    w_nextState = r_cfgParityEn ? PARITYBIT : STOPBIT;
                end
            end
            PARITYBIT: begin
                if (w_bitSample) begin
                    w_nextState = STOPBIT;
                end
            end
            STOPBIT: begin
                if (w_bitSample && w_lastStop) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Receive datapath: synchronizer, tick generation and per-bit capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rxSync1     <= 1'b1;
            r_rxSync2     <= 1'b1;
            r_syncPrimed  <= 2'b00;
            r_armed       <= 1'b0;
            r_divCnt      <= '0;
            r_ovsCnt      <= '0;
            r_bitCnt      <= '0;
            r_cfgWidth    <= 4'd8;
            r_cfgParityEn <= 1'b0;
            r_cfgOdd      <= 1'b0;
            r_cfgTwoStop  <= 1'b0;
            r_shift       <= '0;
            r_parAcc      <= 1'b0;
            r_allZero     <= 1'b0;
            r_parErr      <= 1'b0;
            r_frmErr      <= 1'b0;
            r_brkErr      <= 1'b0;
            r_frameDone   <= 1'b0;
        end else begin
            r_rxSync1    <= rx;
            r_rxSync2    <= r_rxSync1;
            // The reset value of the synchronizer must not count as seeing idle line.
            r_syncPrimed <= {r_syncPrimed[0], 1'b1};
            r_frameDone  <= 1'b0;

            if (w_startDet || w_tick) begin
                r_divCnt <= '0;
            end else begin
                r_divCnt <= r_divCnt + 1'b1;
            end

            if (r_state == IDLE) begin
                r_ovsCnt <= '0;
            end else if (w_tick) begin
                if ((r_state == STARTBIT && r_ovsCnt == c_HALF_LAST) || r_ovsCnt == c_FULL_LAST) begin
                    r_ovsCnt <= '0;
                end else begin
                    r_ovsCnt <= r_ovsCnt + 1'b1;
                end
            end

            if (w_startDet) begin
                r_armed       <= 1'b0;
                r_cfgWidth    <= w_widthClamped;
                r_cfgParityEn <= cfgParityEnable;
                r_cfgOdd      <= cfgParityType;
                r_cfgTwoStop  <= (cfgStopBits == 2'd2);
                r_shift       <= '0;
                r_parAcc      <= 1'b0;
                r_allZero     <= 1'b1;
                r_parErr      <= 1'b0;
                r_frmErr      <= 1'b0;
                r_brkErr      <= 1'b0;
                r_bitCnt      <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_tick && r_rxSync2 && r_syncPrimed[1]) begin
                            r_armed <= 1'b1;
                        end
                    end
                    DATABITS: begin
                        if (w_bitSample) begin
                            if (r_rxSync2) begin
                                r_shift <= r_shift | w_bitSel;
                            end
                            r_parAcc  <= r_parAcc ^ r_rxSync2;
                            r_allZero <= r_allZero & ~r_rxSync2;
                            r_bitCnt  <= w_lastData ? 4'd0 : r_bitCnt + 4'd1;
                        end
                    end
                    PARITYBIT: begin
                        if (w_bitSample) begin
                            r_parErr  <= ((r_parAcc ^ r_rxSync2) != r_cfgOdd);
                            r_allZero <= r_allZero & ~r_rxSync2;
                        end
                    end
                    STOPBIT: begin
                        if (w_bitSample) begin
                            if (!r_rxSync2) begin
                                r_frmErr <= 1'b1;
                            end
                            if (r_bitCnt == 4'd0) begin
                                r_brkErr <= r_allZero & ~r_rxSync2;
                            end
                            if (w_lastStop) begin
                                r_frameDone <= 1'b1;
                                r_armed     <= r_rxSync2;
                                r_bitCnt    <= 4'd0;
                            end else begin
                                r_bitCnt    <= r_bitCnt + 4'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Output holding register; a completed frame is dropped if the last one is still pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            rxData       <= '0;
            rxValid      <= 1'b0;
            parityError  <= 1'b0;
            framingError <= 1'b0;
            breakError   <= 1'b0;
            overrunError <= 1'b0;
        end else if (r_frameDone && (!rxValid || rxReady)) begin
            rxData       <= r_shift;
            rxValid      <= 1'b1;
            parityError  <= r_parErr;
            framingError <= r_frmErr;
            breakError   <= r_brkErr;
            overrunError <= 1'b0;
        end else if (r_frameDone) begin
            overrunError <= 1'b1;
        end else if (rxValid && rxReady) begin
            rxValid      <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_deserializer
// Purpose  : Scoreboard bench driving serial frames into uart_rx_deserializer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_deserializer;

    localparam int c_BIT = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [3:0] cfgDataWidth;
    logic       cfgParityEnable;
    logic       cfgParityType;
    logic [1:0] cfgStopBits;
    logic [7:0] rxData;
    logic       rxValid;
    logic       rxReady;
    logic       parityError;
    logic       framingError;
    logic       breakError;
    logic       overrunError;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       frm;
        logic       brk;
        logic       ovr;
    } expFrame_t;

    expFrame_t sb[$];
    expFrame_t mExp;
    int        nChecks    = 0;
    int        nErrors    = 0;
    int        cyc        = 0;
    int        tStart     = 0;
    int        validCnt   = 0;
    bit        measureLat = 1'b0;
    bit        prevValid  = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_deserializer #(
        .DATA_WIDTH  (8),
        .OVERSAMPLING(16),
        .BAUD_DIV    (1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rx             (rx),
        .cfgDataWidth   (cfgDataWidth),
        .cfgParityEnable(cfgParityEnable),
        .cfgParityType  (cfgParityType),
        .cfgStopBits    (cfgStopBits),
        .rxData         (rxData),
        .rxValid        (rxValid),
        .rxReady        (rxReady),
        .parityError    (parityError),
        .framingError   (framingError),
        .breakError     (breakError),
        .overrunError   (overrunError)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives one frame using the current cfg* settings and queues its expected result.
    task automatic sendFrame(input logic [7:0] d, input logic parBit, input logic [1:0] stops,
                             input bit push, input bit ovr);
        int         nb = (cfgDataWidth >= 4'd5 && cfgDataWidth <= 4'd8) ? int'(cfgDataWidth) : 8;
        int         ns = (cfgStopBits == 2'd2) ? 2 : 1;
        logic [7:0] md = d & 8'((1 << nb) - 1);
        expFrame_t  e;
        e.data = md;
        e.par  = cfgParityEnable ? (((^md) ^ parBit) != cfgParityType) : 1'b0;
        e.frm  = !stops[0] || (ns == 2 && !stops[1]);
        e.brk  = (md == 8'h00) && (!cfgParityEnable || !parBit) && !stops[0];
        e.ovr  = ovr;
        if (push) sb.push_back(e);
        @(negedge clk);
        rx     = 1'b0;
        tStart = cyc + 1;
        repeat (c_BIT) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            rx = d[i];
            repeat (c_BIT) @(negedge clk);
        end
        if (cfgParityEnable) begin
            rx = parBit;
            repeat (c_BIT) @(negedge clk);
        end
        for (int s = 0; s < ns; s++) begin
            rx = stops[s];
            repeat (c_BIT) @(negedge clk);
        end
        rx = 1'b1;
        repeat (2 * c_BIT) @(negedge clk);
    endtask

    task automatic waitDrain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkVal("drain", 32'(sb.size()), 32'd0);
    endtask

    // Output monitor: compares each accepted frame against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rxValid) validCnt++;
            if (measureLat && rxValid && !prevValid) begin
                checkVal("latency", 32'(cyc - tStart), 32'd155);
                measureLat = 1'b0;
            end
            prevValid = rxValid;
            if (rxValid && rxReady) begin
                if (sb.size() == 0) begin
                    checkVal("spurious_valid", 32'(rxValid), 32'd0);
                end else begin
                    mExp = sb.pop_front();
                    checkVal("data", 32'(rxData), 32'(mExp.data));
                    checkVal("parity_err", 32'(parityError), 32'(mExp.par));
                    checkVal("framing_err", 32'(framingError), 32'(mExp.frm));
                    checkVal("break_err", 32'(breakError), 32'(mExp.brk));
                    checkVal("overrun_err", 32'(overrunError), 32'(mExp.ovr));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        reset           = 1'b1;
        rx              = 1'b1;
        cfgDataWidth    = 4'd8;
        cfgParityEnable = 1'b0;
        cfgParityType   = 1'b0;
        cfgStopBits     = 2'd1;
        rxReady         = 1'b1;
        repeat (4) @(negedge clk);
        checkVal("rst_valid", 32'(rxValid), 32'd0);
        checkVal("rst_data", 32'(rxData), 32'd0);
        checkVal("rst_par", 32'(parityError), 32'd0);
        checkVal("rst_frm", 32'(framingError), 32'd0);
        checkVal("rst_brk", 32'(breakError), 32'd0);
        checkVal("rst_ovr", 32'(overrunError), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // 8N1 with latency and single-cycle valid pulse
        validCnt   = 0;
        measureLat = 1'b1;
        sendFrame(8'hA5, 1'b0, 2'b11, 1'b1, 1'b0);
        waitDrain();
        checkVal("pulse_len", 32'(validCnt), 32'd1);
        checkVal("latency_seen", 32'(measureLat), 32'd0);

        // 7E1 wrong then right parity
        cfgDataWidth    = 4'd7;
        cfgParityEnable = 1'b1;
        cfgParityType   = 1'b0;
        sendFrame(8'h35, 1'b1, 2'b11, 1'b1, 1'b0);
        sendFrame(8'h35, 1'b0, 2'b11, 1'b1, 1'b0);
        waitDrain();

        // 8N1 framing / break
        cfgDataWidth    = 4'd8;
        cfgParityEnable = 1'b0;
        sendFrame(8'h00, 1'b0, 2'b10, 1'b1, 1'b0);
        sendFrame(8'h01, 1'b0, 2'b10, 1'b1, 1'b0);
        waitDrain();

        // 6O2 with second stop bit low
        cfgDataWidth    = 4'd6;
        cfgParityEnable = 1'b1;
        cfgParityType   = 1'b1;
        cfgStopBits     = 2'd2;
        sendFrame(8'h2C, 1'b0, 2'b01, 1'b1, 1'b0);
        waitDrain();

        // Out-of-range config falls back to 8 data bits, 1 stop bit
        cfgDataWidth    = 4'd3;
        cfgParityEnable = 1'b0;
        cfgParityType   = 1'b0;
        cfgStopBits     = 2'd0;
        sendFrame(8'hC3, 1'b0, 2'b11, 1'b1, 1'b0);
        waitDrain();

        // Overrun
        cfgDataWidth = 4'd8;
        cfgStopBits  = 2'd1;
        rxReady      = 1'b0;
        sendFrame(8'h11, 1'b0, 2'b11, 1'b1, 1'b1);
        sendFrame(8'h22, 1'b0, 2'b11, 1'b0, 1'b0);
        checkVal("ovr_valid", 32'(rxValid), 32'd1);
        checkVal("ovr_data", 32'(rxData), 32'h11);
        checkVal("ovr_flag", 32'(overrunError), 32'd1);
        rxReady = 1'b1;
        @(negedge clk);
        checkVal("ovr_clear", 32'(rxValid), 32'd0);
        checkVal("ovr_hold", 32'(overrunError), 32'd1);
        waitDrain();

        // Glitch shorter than half a bit
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * c_BIT) @(negedge clk);
        checkVal("glitch_valid", 32'(rxValid), 32'd0);
        sendFrame(8'h5A, 1'b0, 2'b11, 1'b1, 1'b0);
        waitDrain();

        // Reset during data bit 3
        fork
            sendFrame(8'h07, 1'b0, 2'b11, 1'b0, 1'b0);
            begin
                repeat (4 * c_BIT + 6) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                checkVal("midrst_data", 32'(rxData), 32'd0);
                checkVal("midrst_valid", 32'(rxValid), 32'd0);
                checkVal("midrst_flags", {28'd0, parityError, framingError, breakError, overrunError}, 32'd0);
            end
        join
        checkVal("midrst_novalid", 32'(rxValid), 32'd0);
        sendFrame(8'h3C, 1'b0, 2'b11, 1'b1, 1'b0);
        waitDrain();

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
